// File: rtl/fifo_byte_reader.sv
// ----------------------------------------------------------------------------
// fifo_byte_reader
//
// Pulls whole words out of a FIFO that has registered read data. Each word is
// sent downstream one byte at a time over a valid/ready byte stream. Bytes go
// out most-significant first by default, or least-significant first when
// MSB_FIRST = 0. A 16-bit counter records how many words have been fully
// transmitted.
//
// Parameters
//   BUF_LENGTH  MSB index of a FIFO word (word width is BUF_LENGTH+1)
//   WORD_BYTES  bytes per FIFO word; BUF_LENGTH+1 must equal 8*WORD_BYTES
//   MSB_FIRST   1: most significant byte first, 0: least significant first
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst         asynchronous, active-low reset
//   en          allows new word fetches (looked at in IDLE and at word end)
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after an accepted read
//   fifo_rd_en  FIFO read strobe, one single-cycle pulse per word
//   tx_data     byte to downstream
//   tx_valid    tx_data is valid
//   tx_ready    downstream takes the byte when tx_valid && tx_ready at an edge
//   busy        high whenever the reader is not IDLE
//   word_cnt    number of fully transmitted words, wraps at 0xFFFF
// ----------------------------------------------------------------------------
module fifo_byte_reader #(
    parameter int BUF_LENGTH = 31,
    parameter int WORD_BYTES = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                fifo_empty,
    input  logic [BUF_LENGTH:0] fifo_data,
    output logic                fifo_rd_en,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic [15:0]         word_cnt
);

    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POP  = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
    localparam logic [1:0] S_SEND = 2'd3;

    if ((BUF_LENGTH + 1) != (8 * WORD_BYTES)) begin : g_bad_cfg
        $error("fifo_byte_reader: BUF_LENGTH+1 must equal 8*WORD_BYTES");
    end

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BUF_LENGTH:0] word_q, word_d;
    logic [15:0]         word_cnt_q, word_cnt_d;

    logic [IDX_W-1:0]    sel;
    logic [7:0]          byte_sel;
    logic                fetch_ok;

    // A new word is only fetched when enabled and the FIFO has data at the
    // decision edge; this guards both the IDLE exit and the word-end exit.
    assign fetch_ok = en && !fifo_empty;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        word_cnt_d = word_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_ok) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // The FIFO presents the popped word during this cycle.
                word_d  = fifo_data;
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        word_cnt_d = word_cnt_q + 16'd1;
                        state_d    = fetch_ok ? S_POP : S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            word_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Byte lane for the current index. With MSB_FIRST the index counts down
    // from the top lane, so index 0 maps to bits [BUF_LENGTH -: 8].
    assign sel = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;

    always_comb begin
        byte_sel = 8'h00;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (sel == IDX_W'(b)) begin
                byte_sel = word_q[8*b +: 8];
            end
        end
    end

    // Outputs are Moore-decoded from the state register, so the asynchronous
    // reset clears them immediately. tx_data is gated to 0 outside SEND.
    assign fifo_rd_en = (state_q == S_POP);
    assign tx_valid   = (state_q == S_SEND);
    assign tx_data    = tx_valid ? byte_sel : 8'h00;
    assign busy       = (state_q != S_IDLE);
    assign word_cnt   = word_cnt_q;

endmodule

// File: doc/fifo_byte_reader.md
FIFO_BYTE_READER -- requirements
Module: fifo_byte_reader

Interface
REQ-001 Parameter BUF_LENGTH, default 31, MSB index of FIFO word (word width BUF_LENGTH+1 = 32).
REQ-002 Parameter WORD_BYTES, default 4, bytes emitted per FIFO word; (BUF_LENGTH+1) SHALL equal 8*WORD_BYTES.
REQ-003 Parameter MSB_FIRST, default 1, 1 = most significant byte emitted first, 0 = least significant first.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  enable new word fetches; sampled only in IDLE and at word end.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 fifo_data  input  BUF_LENGTH+1  FIFO registered read data, valid the cycle after an accepted read.
REQ-009 fifo_rd_en  output  1  FIFO read strobe, single-cycle pulse per word.
REQ-010 tx_data  output  8  byte to downstream.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_ready  input  1  downstream accepts byte when tx_valid && tx_ready at rising edge.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 word_cnt  output  16  count of fully transmitted words, wraps 0xFFFF -> 0x0000.

Function
REQ-015 FSM states SHALL be IDLE, POP, LOAD, SEND, all outputs registered or Moore-decoded from state.
REQ-016 IDLE -> POP when en=1 and fifo_empty=0; otherwise stay IDLE.
REQ-017 POP: fifo_rd_en=1 for exactly this one cycle; unconditional -> LOAD.
REQ-018 LOAD: fifo_rd_en=0; fifo_data captured into word register at end of cycle; byte index cleared to 0; -> SEND.
REQ-019 SEND: tx_valid=1; tx_data = byte[index] of word register (index 0 = bits [BUF_LENGTH:BUF_LENGTH-7] if MSB_FIRST=1, else bits [7:0]).
REQ-020 In SEND with tx_ready=0, tx_data and tx_valid SHALL hold unchanged (no byte dropped, no byte changed).
REQ-021 In SEND with tx_ready=1 and index < WORD_BYTES-1: index increments, stay SEND.
REQ-022 In SEND with tx_ready=1 and index = WORD_BYTES-1: word_cnt increments; -> POP if en=1 and fifo_empty=0, else -> IDLE.
REQ-023 Latency: fifo_empty falls before edge N in IDLE with en=1 -> fifo_rd_en high cycle N+1 -> first tx_valid cycle N+3.
REQ-024 Back-to-back words: last byte accepted at edge M -> next word first byte valid at cycle M+3 (POP, LOAD, SEND); two idle tx cycles between words.
REQ-025 fifo_rd_en SHALL never assert while fifo_empty was 1 at the decision edge; no read is issued in LOAD or SEND.
REQ-026 en deassertion during POP, LOAD or SEND SHALL NOT abort the word; current word completes, then IDLE.
REQ-027 tx_valid SHALL be 0 in IDLE, POP and LOAD.
REQ-028 Byte index width = clog2(WORD_BYTES), minimum 1 bit; never exceeds WORD_BYTES-1.

Reset
REQ-029 rst=0 SHALL immediately (asynchronously) force state IDLE, fifo_rd_en=0, tx_valid=0, tx_data=0x00, busy=0, word_cnt=0, index=0, word register=0.
REQ-030 Reset during SEND SHALL discard the partial word; no remaining bytes emitted after release.
REQ-031 After rst rises, first possible fifo_rd_en is the cycle after the first edge that samples IDLE with en=1, fifo_empty=0.

Verification
REQ-032 Single word: FIFO holds 0x11223344, en=1, tx_ready=1 -> exactly one fifo_rd_en pulse; bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles; word_cnt=1; busy falls after last byte.
REQ-033 Backpressure: word 0xA1B2C3D4, tx_ready toggles 1,0,0,1,0,1,1 -> bytes 0xA1,0xB2,0xC3,0xD4 in order, tx_data stable during every ready=0 cycle, no duplicates.
REQ-034 Back-to-back: 3 words 0x00000001,0x00000002,0x00000003 preloaded, tx_ready=1 -> 12 bytes in order, exactly 2 tx_valid=0 cycles between words, 3 rd_en pulses, word_cnt=3.
REQ-035 Empty/enable: fifo_empty=1 or en=0 for 100 cycles -> fifo_rd_en never asserts, tx_valid=0; en dropped mid-word -> word completes, then IDLE with data still in FIFO.
REQ-036 Reset mid-word: rst=0 after second byte of 0xDEADBEEF accepted -> outputs reset in same cycle; after release with FIFO empty, no 0xBE/0xEF emitted.
REQ-037 Wrap and order: word_cnt preset path via 65536 words -> reads 0x0000; MSB_FIRST=0 with 0x11223344 -> 0x44,0x33,0x22,0x11.
